// File: rtl/codec_config_sequencer.sv
// codec_config_sequencer
// Walks the WM8731 power-up register table and issues one 3-byte I2C write per
// entry through an external transfer engine. NACKed writes are retried. After
// the codec reset write (entry 0) the sequencer idles for a settle interval.
// audio_enable rises only once every entry has been acknowledged, so it can
// hold the audio datapath in reset until then.
module codec_config_sequencer #(
  parameter logic [7:0] CODEC_ADDR    = 8'h34,
  parameter int         RETRY_MAX     = 3,
  parameter int         SETTLE_CYCLES = 50000,
  parameter bit         AUTO_START    = 1'b1
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        start,
  input  logic        use_mic_input,
  output logic        i2c_go,
  output logic [23:0] i2c_data,
  input  logic        i2c_busy,
  input  logic        i2c_done,
  input  logic        i2c_ack_err,
  output logic        busy,
  output logic        config_done,
  output logic        config_error,
  output logic [3:0]  reg_index,
  output logic        audio_enable
);

  localparam int SETTLE_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam int RETRY_W  = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  localparam logic [3:0]          LAST_INDEX  = 4'd10;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0]  RETRY_LIMIT = RETRY_W'(RETRY_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_SETTLE,
    S_NEXT,
    S_DONE,
    S_FAIL
  } state_t;

  // Register table entry as {7-bit register address, 9-bit value}.
  function automatic logic [15:0] table_entry(input logic [3:0] idx, input logic mic);
    logic [6:0] addr;
    logic [8:0] value;
    addr  = 7'd0;
    value = 9'h000;
    case (idx)
      4'd0:    begin addr = 7'd15; value = 9'h000; end
      4'd1:    begin addr = 7'd0;  value = 9'h017; end
      4'd2:    begin addr = 7'd1;  value = 9'h017; end
      4'd3:    begin addr = 7'd2;  value = 9'h06B; end
      4'd4:    begin addr = 7'd3;  value = 9'h06B; end
      4'd5:    begin addr = 7'd4;  value = mic ? 9'h015 : 9'h012; end
      4'd6:    begin addr = 7'd5;  value = 9'h000; end
      4'd7:    begin addr = 7'd6;  value = 9'h000; end
      4'd8:    begin addr = 7'd7;  value = 9'h00A; end
      4'd9:    begin addr = 7'd8;  value = 9'h000; end
      4'd10:   begin addr = 7'd9;  value = 9'h001; end
      default: begin addr = 7'd0;  value = 9'h000; end
    endcase
    return {addr, value};
  endfunction

  state_t              r_state;
  logic                r_auto;
  logic                r_mic;
  logic                r_nack;
  logic                r_go;
  logic                r_busy;
  logic                r_done;
  logic                r_error;
  logic [3:0]          r_index;
  logic [23:0]         r_data;
  logic [RETRY_W-1:0]  r_retry;
  logic [SETTLE_W-1:0] r_settle;

  logic [3:0]  w_next_index;
  logic [15:0] w_next_entry;
  logic [15:0] w_first_entry;

  assign w_next_index  = r_index + 4'd1;
  assign w_next_entry  = table_entry(w_next_index, r_mic);
  // Entry 0 is built from the live pin because the mic selection is latched on the same edge.
  assign w_first_entry = table_entry(4'd0, use_mic_input);

  // Sequencer state machine; every output comes straight from a register here.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_auto   <= AUTO_START;
      r_mic    <= 1'b0;
      r_nack   <= 1'b0;
      r_go     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_index  <= 4'd0;
      r_data   <= 24'd0;
      r_retry  <= '0;
      r_settle <= '0;
    end else begin
      r_go <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start || r_auto) begin
            r_auto  <= 1'b0;
            r_mic   <= use_mic_input;
            r_index <= 4'd0;
            r_retry <= '0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_busy  <= 1'b1;
            r_data  <= {CODEC_ADDR, w_first_entry};
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!i2c_busy) begin
            r_go    <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i2c_done) begin
            r_nack  <= i2c_ack_err;
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (!r_nack) begin
            if ((r_index == 4'd0) && (SETTLE_CYCLES > 0)) begin
              r_settle <= '0;
              r_state  <= S_SETTLE;
            end else begin
              r_state <= S_NEXT;
            end
          end else if (r_retry < RETRY_LIMIT) begin
            r_retry <= r_retry + RETRY_W'(1);
            r_state <= S_ISSUE;
          end else begin
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_FAIL;
          end
        end
        S_SETTLE: begin
          if (r_settle == SETTLE_LAST) begin
            r_state <= S_NEXT;
          end else begin
            r_settle <= r_settle + SETTLE_W'(1);
          end
        end
        S_NEXT: begin
          r_retry <= '0;
          if (r_index == LAST_INDEX) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_index <= w_next_index;
            r_data  <= {CODEC_ADDR, w_next_entry};
            r_state <= S_ISSUE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign i2c_go       = r_go;
  assign i2c_data     = r_data;
  assign busy         = r_busy;
  assign config_done  = r_done;
  assign config_error = r_error;
  assign reg_index    = r_index;
  assign audio_enable = r_done;

endmodule
